// File: rtl/metronome_click_decoder.sv
// Recovers beat onsets from the metronome beep line; 1-cycle strobe 4 clks after the confirming pin edge.
// No backpressure: strobes are fire-and-forget, beat number shown on a 7-segment display.
module metronome_click_decoder #(
    parameter int PW            = 18,
    parameter int C_PERIOD      = 97408,
    parameter int G_PERIOD      = 65014,
    parameter int TOL           = 1024,
    parameter int CONFIRM       = 4,
    parameter int GAP_CYCLES    = 200000,
    parameter int RESYNC_CYCLES = 54000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tone_in,
    output logic          a,
    output logic          b,
    output logic          c,
    output logic          d,
    output logic          e,
    output logic          f,
    output logic          g,
    output logic          beat_pulse,
    output logic          accent,
    output logic [1:0]    tone_class,
    output logic [PW-1:0] period_out
);
    localparam int SW = $clog2(RESYNC_CYCLES + 1);
    localparam int CW = $clog2(CONFIRM + 1);
    localparam logic [PW-1:0] P_MAX     = '1;
    localparam logic [PW:0]   C_LO      = (PW+1)'(C_PERIOD - TOL);
    localparam logic [PW:0]   C_HI      = (PW+1)'(C_PERIOD + TOL);
    localparam logic [PW:0]   G_LO      = (PW+1)'(G_PERIOD - TOL);
    localparam logic [PW:0]   G_HI      = (PW+1)'(G_PERIOD + TOL);
    localparam logic [SW-1:0] GAP_M1    = SW'(GAP_CYCLES - 1);
    localparam logic [SW-1:0] RS_M1     = SW'(RESYNC_CYCLES - 1);
    localparam logic [SW-1:0] RS_MAX    = SW'(RESYNC_CYCLES);
    localparam logic [CW-1:0] CONF_M1   = CW'(CONFIRM - 1);

    typedef enum logic [1:0] {IDLE, ARMED, LOCKING, TONE_ON} state_t;

    state_t        r_state;
    logic          r_s1, r_s2, r_s3, r_edge;
    logic [PW-1:0] r_cnt;
    logic [SW-1:0] r_sil;
    logic [CW-1:0] r_match;
    logic          r_lock_g;
    logic [3:0]    r_beat;
    logic          r_beat_pulse, r_accent;
    logic [1:0]    r_tone_class;
    logic [PW-1:0] r_period;

    logic [PW-1:0] w_p;
    logic          w_is_c, w_is_g, w_valid;
    logic [6:0]    w_seg;

    // A saturated count means we never saw the previous edge in range.
    assign w_p     = (r_cnt == P_MAX) ? P_MAX : r_cnt + 1'b1;
    assign w_is_c  = (w_p != P_MAX) && ({1'b0, w_p} >= C_LO) && ({1'b0, w_p} <= C_HI);
    assign w_is_g  = (w_p != P_MAX) && !w_is_c && ({1'b0, w_p} >= G_LO) && ({1'b0, w_p} <= G_HI);
    assign w_valid = w_is_c || w_is_g;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0; r_s2 <= 1'b0; r_s3 <= 1'b0; r_edge <= 1'b0;
            r_cnt <= '0; r_sil <= '0; r_match <= '0; r_lock_g <= 1'b0;
            r_beat <= 4'd0; r_state <= IDLE;
            r_beat_pulse <= 1'b0; r_accent <= 1'b0;
            r_tone_class <= 2'd0; r_period <= '0;
        end else begin
            r_s1   <= tone_in;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_edge <= r_s2 & ~r_s3;
            r_beat_pulse <= 1'b0;
            r_accent     <= 1'b0;

            if (r_edge) begin
                r_cnt    <= '0;
                r_sil    <= '0;
                r_period <= w_p;
                case (r_state)
                    IDLE: r_state <= ARMED;
                    ARMED: begin
                        if (w_valid) begin
                            r_match  <= CW'(1);
                            r_lock_g <= w_is_g;
                            r_state  <= LOCKING;
                        end
                    end
                    LOCKING: begin
                        if (!w_valid) begin
                            r_match <= '0;
                            r_state <= ARMED;
                        end else if (w_is_g != r_lock_g) begin
                            r_match  <= CW'(1);
                            r_lock_g <= w_is_g;
                        end else begin
                            r_match <= r_match + 1'b1;
                            if (r_match == CONF_M1) begin
                                r_state      <= TONE_ON;
                                r_beat_pulse <= 1'b1;
                                r_accent     <= r_lock_g;
                                r_tone_class <= r_lock_g ? 2'd2 : 2'd1;
                                r_beat       <= (r_beat == 4'd8) ? 4'd1 : r_beat + 4'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end else begin
                if (r_cnt != P_MAX) r_cnt <= r_cnt + 1'b1;
                if (r_sil != RS_MAX) r_sil <= r_sil + 1'b1;
                if (r_sil == RS_M1) r_beat <= 4'd0;
                // An edge in the same cycle wins, so the timeout only fires here.
                if (r_state != IDLE && r_sil >= GAP_M1) begin
                    r_state      <= IDLE;
                    r_tone_class <= 2'd0;
                    r_match      <= '0;
                end
            end
        end
    end

    always_comb begin
        w_seg = 7'b0000000;
        case (r_beat)
            4'd0: w_seg = 7'b1111110;
            4'd1: w_seg = 7'b0110000;
            4'd2: w_seg = 7'b1101101;
            4'd3: w_seg = 7'b1111001;
            4'd4: w_seg = 7'b0110011;
            4'd5: w_seg = 7'b1011011;
            4'd6: w_seg = 7'b1011111;
            4'd7: w_seg = 7'b1110000;
            4'd8: w_seg = 7'b1111111;
            default: w_seg = 7'b0000000;
        endcase
    end

    assign {a, b, c, d, e, f, g} = w_seg;
    assign beat_pulse = r_beat_pulse;
    assign accent     = r_accent;
    assign tone_class = r_tone_class;
    assign period_out = r_period;
endmodule

// File: tb/tb_metronome_click_decoder.sv
// Directed bench for metronome_click_decoder using scaled-down periods and timeouts.
module tb_metronome_click_decoder;
    localparam int PW   = 10;
    localparam int CP   = 200;
    localparam int GP   = 140;
    localparam int TOL  = 8;
    localparam int CONF = 4;
    localparam int GAP  = 500;
    localparam int RS   = 5000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tone_in = 1'b0;
    logic a, b, c, d, e, f, g;
    logic beat_pulse, accent;
    logic [1:0] tone_class;
    logic [PW-1:0] period_out;

    metronome_click_decoder #(
        .PW(PW), .C_PERIOD(CP), .G_PERIOD(GP), .TOL(TOL),
        .CONFIRM(CONF), .GAP_CYCLES(GAP), .RESYNC_CYCLES(RS)
    ) dut (
        .clk(clk), .rst(rst), .tone_in(tone_in),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .beat_pulse(beat_pulse), .accent(accent),
        .tone_class(tone_class), .period_out(period_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pulse = 0;
    int last_pulse_cyc = 0;
    int last_acc = 0;
    int last_cls = 0;
    always @(negedge clk) begin
        if (beat_pulse) begin
            n_pulse        = n_pulse + 1;
            last_pulse_cyc = cyc;
            last_acc       = int'(accent);
            last_cls       = int'(tone_class);
        end
    end

    int n_vec = 0;
    int n_bad = 0;
    int edge_cyc [0:15];

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec = n_vec + 1;
        if (obs != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic int seg_of(input int dig);
        case (dig)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            default: return 0;
        endcase
    endfunction

    function automatic int seg_now();
        logic [6:0] s;
        s = {a, b, c, d, e, f, g};
        return int'(s);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tone_in = 1'b0;
        idle(3);
        rst = 1'b0;
    endtask

    // Rising edges spaced exactly per cycles; returns with the pin low, per cycles after the last rise.
    task automatic square(input int n, input int per);
        for (int i = 0; i < n; i++) begin
            tone_in = 1'b1;
            if (i < 16) edge_cyc[i] = cyc;
            idle(per / 2);
            tone_in = 1'b0;
            idle(per - per / 2);
        end
    endtask

    int p0;

    initial begin
        idle(1);
        do_reset();
        chk("rst_pulse", int'(beat_pulse), 0);
        chk("rst_accent", int'(accent), 0);
        chk("rst_class", int'(tone_class), 0);
        chk("rst_period", int'(period_out), 0);
        chk("rst_seg", seg_now(), seg_of(0));

        p0 = n_pulse;
        square(10, CP);
        chk("c_npulse", n_pulse - p0, 1);
        chk("c_latency", last_pulse_cyc - edge_cyc[4], 4);
        chk("c_accent", last_acc, 0);
        chk("c_class_at_pulse", last_cls, 1);
        chk("c_class", int'(tone_class), 1);
        chk("c_seg", seg_now(), seg_of(1));
        chk("c_period", int'(period_out), CP);
        idle(600);
        chk("c_gap_class", int'(tone_class), 0);

        do_reset();
        p0 = n_pulse;
        square(10, GP);
        chk("g_npulse", n_pulse - p0, 1);
        chk("g_latency", last_pulse_cyc - edge_cyc[4], 4);
        chk("g_accent", last_acc, 1);
        chk("g_class", int'(tone_class), 2);
        chk("g_seg", seg_now(), seg_of(1));
        chk("g_period", int'(period_out), GP);

        do_reset();
        p0 = n_pulse;
        square(10, CP + TOL);
        chk("tol_in_npulse", n_pulse - p0, 1);
        do_reset();
        p0 = n_pulse;
        square(10, CP + TOL + 1);
        idle(600);
        chk("tol_out_npulse", n_pulse - p0, 0);
        chk("tol_out_period", int'(period_out), CP + TOL + 1);
        chk("tol_out_seg", seg_now(), seg_of(0));

        do_reset();
        for (int bi = 0; bi < 9; bi++) begin
            p0 = n_pulse;
            square(6, CP);
            chk("burst_npulse", n_pulse - p0, 1);
            chk("burst_seg", seg_now(), seg_of((bi % 8) + 1));
            idle(700);
            chk("burst_gap_class", int'(tone_class), 0);
        end

        do_reset();
        p0 = n_pulse;
        square(3, CP);
        square(4, GP);
        idle(600);
        chk("switch_npulse", n_pulse - p0, 0);
        chk("switch_class", int'(tone_class), 0);

        do_reset();
        for (int bi = 0; bi < 3; bi++) begin
            square(6, CP);
            idle(700);
        end
        chk("pre_resync_seg", seg_now(), seg_of(3));
        idle(RS);
        chk("resync_seg", seg_now(), seg_of(0));
        p0 = n_pulse;
        square(6, CP);
        chk("post_resync_npulse", n_pulse - p0, 1);
        chk("post_resync_seg", seg_now(), seg_of(1));
        idle(700);

        square(3, CP);
        rst = 1'b1;
        idle(1);
        chk("mid_rst_pulse", int'(beat_pulse), 0);
        chk("mid_rst_accent", int'(accent), 0);
        chk("mid_rst_class", int'(tone_class), 0);
        chk("mid_rst_period", int'(period_out), 0);
        chk("mid_rst_seg", seg_now(), seg_of(0));
        rst = 1'b0;
        p0 = n_pulse;
        square(6, CP);
        chk("after_rst_npulse", n_pulse - p0, 1);
        chk("after_rst_latency", last_pulse_cyc - edge_cyc[4], 4);
        chk("after_rst_seg", seg_now(), seg_of(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
